// File: rtl/lane_slot_scheduler_pkg.sv
// Shared constants for the lane slot scheduler.
// Holds the default lane count, byte width, idle filler byte and the derived slot and
// frame lengths. Also holds a helper that gives the index width for a count.
package lane_slot_scheduler_pkg;

  // Index width for a count. A count of 1 still needs a 1-bit signal.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NumLanesDef = 4;
  localparam int unsigned DataWDef    = 8;
  localparam logic [DataWDef-1:0] IdleByteDef = 8'hBC;

  // One slot carries one byte, one bit per cycle.
  localparam int unsigned SlotLen  = DataWDef;
  localparam int unsigned FrameLen = NumLanesDef * SlotLen;
  localparam int unsigned SlotIdxW = idx_w(NumLanesDef);

endpackage

// File: rtl/lane_slot_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req_i starting at ptr_i and wraps modulo N. It returns the first requester.
//   req_i  : request vector
//   ptr_i  : lane with highest priority this round
//   gnt_o  : one-hot winner, or 0 when there is no request
//   idx_o  : binary index of the winner, or 0 when there is no request
//   any_o  : at least one request is set
module lane_slot_scheduler_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  // ptr_i + k is always below 2N, so a single subtract wraps it.
  function automatic int unsigned wrap(int unsigned a);
    return (a >= N) ? a - N : a;
  endfunction

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IdxW'(wrap(32'(ptr_i) + k));
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/lane_slot_scheduler.sv
// Time-division scheduler for the shared serial link.
// A frame has NUM_LANES slots, and each slot lasts DATA_W cycles. Each slot sends one
// byte MSB-first. The byte comes from the round-robin winner among the requesting
// lanes. If no lane requests, the slot sends IDLE_BYTE.
//   clk32f        : serial-rate clock; all logic runs on its posedge
//   rst           : synchronous, active-high reset
//   req_i         : lane i has a byte pending
//   data_in_i     : byte of lane i at [i*DATA_W +: DATA_W]
//   ack_o         : one-cycle one-hot pulse in the bit-0 cycle when a byte is taken
//   grant_o       : one-hot owner of the current slot, or 0 when the slot is idle
//   ser_out_o     : serial bit, MSB first
//   ser_valid_o   : high while the slot carries data from a granted lane
//   slot_idx_o    : number of the current slot within the frame
//   frame_start_o : high in the first cycle of each frame
module lane_slot_scheduler
  import lane_slot_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LANES = NumLanesDef,
  parameter int unsigned DATA_W    = DataWDef,
  parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(IdleByteDef),
  localparam int unsigned SlotW = idx_w(NUM_LANES)
) (
  input  logic                          clk32f,
  input  logic                          rst,
  input  logic [NUM_LANES-1:0]          req_i,
  input  logic [NUM_LANES*DATA_W-1:0]   data_in_i,
  output logic [NUM_LANES-1:0]          ack_o,
  output logic [NUM_LANES-1:0]          grant_o,
  output logic                          ser_out_o,
  output logic                          ser_valid_o,
  output logic [SlotW-1:0]              slot_idx_o,
  output logic                          frame_start_o
);

  localparam int unsigned BitW = idx_w(DATA_W);

  // The frame counter is split into a bit counter and a slot counter. Both reset to
  // their last value, so the first edge after reset is a load edge into slot 0.
  logic [BitW-1:0]      bit_q, bit_d;
  logic [SlotW-1:0]     slot_q, slot_d;
  logic [SlotW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]    shreg_q, shreg_d;
  logic [NUM_LANES-1:0] ack_q, ack_d;
  logic [NUM_LANES-1:0] grant_q, grant_d;
  logic                 ser_out_q, ser_out_d;
  logic                 ser_valid_q, ser_valid_d;
  logic [SlotW-1:0]     slot_idx_q, slot_idx_d;
  logic                 frame_start_q, frame_start_d;

  logic [NUM_LANES-1:0] win_gnt;
  logic [SlotW-1:0]     win_idx;
  logic                 win_any;
  logic                 load;
  logic [DATA_W-1:0]    ld_byte;

  lane_slot_scheduler_rr_arbiter #(
    .N    (NUM_LANES),
    .IdxW (SlotW)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // The coming edge enters bit 0.
  assign load    = (bit_q == BitW'(DATA_W - 1));
  assign ld_byte = win_any ? data_in_i[32'(win_idx) * DATA_W +: DATA_W] : IDLE_BYTE;

  always_comb begin
    bit_d         = bit_q + BitW'(1);
    slot_d        = slot_q;
    ptr_d         = ptr_q;
    shreg_d       = {shreg_q[DATA_W-2:0], 1'b0};
    ser_out_d     = shreg_q[DATA_W-1];
    ack_d         = '0;
    grant_d       = grant_q;
    ser_valid_d   = ser_valid_q;
    if (load) begin
      bit_d       = '0;
      slot_d      = (slot_q == SlotW'(NUM_LANES - 1)) ? '0 : slot_q + SlotW'(1);
      // The MSB is driven from the load edge itself. The shift register keeps the rest.
      shreg_d     = {ld_byte[DATA_W-2:0], 1'b0};
      ser_out_d   = ld_byte[DATA_W-1];
      ack_d       = win_gnt;
      grant_d     = win_gnt;
      ser_valid_d = win_any;
      if (win_any) begin
        ptr_d = (win_idx == SlotW'(NUM_LANES - 1)) ? '0 : win_idx + SlotW'(1);
      end
    end
    slot_idx_d    = slot_d;
    frame_start_d = load && (slot_d == '0);
  end

  always_ff @(posedge clk32f) begin
    if (rst) begin
      bit_q         <= BitW'(DATA_W - 1);
      slot_q        <= SlotW'(NUM_LANES - 1);
      ptr_q         <= '0;
      shreg_q       <= '0;
      ack_q         <= '0;
      grant_q       <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      slot_idx_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      bit_q         <= bit_d;
      slot_q        <= slot_d;
      ptr_q         <= ptr_d;
      shreg_q       <= shreg_d;
      ack_q         <= ack_d;
      grant_q       <= grant_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      slot_idx_q    <= slot_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ack_o         = ack_q;
  assign grant_o       = grant_q;
  assign ser_out_o     = ser_out_q;
  assign ser_valid_o   = ser_valid_q;
  assign slot_idx_o    = slot_idx_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_lane_slot_scheduler.sv
// Testbench for lane_slot_scheduler. It uses a scoreboard and a slot-level reference
// model. The stimulus pushes one expected slot record for each load edge. The monitor
// checks every cycle of the slot against that record and pops it after the last bit.
module tb_lane_slot_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk32f = 1'b0;
  logic             rst    = 1'b1;
  logic [N-1:0]     req    = '0;
  logic [N*W-1:0]   data_in = '0;
  logic [N-1:0]     ack;
  logic [N-1:0]     grant;
  logic             ser_out;
  logic             ser_valid;
  logic [1:0]       slot_idx;
  logic             frame_start;

  always #5 clk32f = ~clk32f;

  lane_slot_scheduler dut (
    .clk32f        (clk32f),
    .rst           (rst),
    .req_i         (req),
    .data_in_i     (data_in),
    .ack_o         (ack),
    .grant_o       (grant),
    .ser_out_o     (ser_out),
    .ser_valid_o   (ser_valid),
    .slot_idx_o    (slot_idx),
    .frame_start_o (frame_start)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] grant;
    logic [W-1:0] dat;
    logic         valid;
    int           slot;
  } exp_t;

  exp_t sb[$];

  // Reference model state: the lane with priority and the next slot number.
  int m_ptr  = 0;
  int m_slot = 0;

  logic         mon_en = 1'b0;
  int           mbit   = 0;
  logic [W-1:0] mbyte  = '0;
  exp_t         cur;

  always @(negedge clk32f) begin
    if (!mon_en) begin
      mbit = 0;
    end else if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL monitor: slot output with no expected entry at %0t", $time);
    end else begin
      cur = sb[0];
      chk("grant", 32'(grant), 32'(cur.grant));
      chk("ser_valid", 32'(ser_valid), 32'(cur.valid));
      chk("ack", 32'(ack), (mbit == 0) ? 32'(cur.grant) : 32'd0);
      chk("slot_idx", 32'(slot_idx), 32'(cur.slot));
      chk("frame_start", 32'(frame_start), 32'((mbit == 0) && (cur.slot == 0)));
      mbyte = {mbyte[W-2:0], ser_out};
      mbit++;
      if (mbit == W) begin
        chk("ser_byte", 32'(mbyte), 32'(cur.dat));
        void'(sb.pop_front());
        mbit = 0;
      end
    end
  end

  // Runs one slot. The model picks the winner from the current req/data, then the task
  // steps DATA_W cycles. In cycle mid_at it may change the inputs, and the DUT must
  // ignore that change until the next load edge.
  task automatic do_slot(input int mid_at, input logic [N-1:0] mid_req,
                         input logic [N*W-1:0] mid_data);
    exp_t e;
    int   lane;
    e.grant = '0;
    e.dat   = 8'hBC;
    e.valid = 1'b0;
    e.slot  = m_slot;
    for (int k = 0; k < N; k++) begin
      lane = (m_ptr + k) % N;
      if (req[lane]) begin
        e.grant = N'(1) << lane;
        e.dat   = data_in[lane*W +: W];
        e.valid = 1'b1;
        m_ptr   = (lane + 1) % N;
        break;
      end
    end
    m_slot = (m_slot + 1) % N;
    sb.push_back(e);
    for (int k = 0; k < W; k++) begin
      @(posedge clk32f);
      #1;
      if (k == 0) mon_en = 1'b1;
      if (k == mid_at) begin
        req     = mid_req;
        data_in = mid_data;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_ser_out"}, 32'(ser_out), 32'd0);
    chk({tag, "_ser_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_slot_idx"}, 32'(slot_idx), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    // Reset held for 3 cycles.
    repeat (3) begin
      @(posedge clk32f);
      #1;
    end
    chk_all_zero("reset");
    rst    = 1'b0;
    m_ptr  = 0;
    m_slot = 0;

    // No requests: idle bytes for one full frame.
    for (int s = 0; s < 4; s++) do_slot(-1, '0, '0);

    // Lane 0 holds 0xA5 for a full frame.
    req     = 4'b0001;
    data_in = {8'h00, 8'h00, 8'h00, 8'hA5};
    for (int s = 0; s < 4; s++) do_slot(-1, '0, '0);

    // All lanes request: grants rotate.
    req     = 4'b1111;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int s = 0; s < 8; s++) do_slot(-1, '0, '0);

    // Serve lane 2, so the pointer moves to 3. Then lanes 1 and 2 request.
    req = 4'b0100;
    do_slot(-1, '0, '0);
    req = 4'b0110;
    do_slot(-1, '0, '0);
    do_slot(-1, '0, '0);

    // A request that rises at bit 3 is not granted until the next load edge.
    req     = 4'b0000;
    data_in = {8'h5A, 8'h00, 8'h00, 8'h00};
    do_slot(3, 4'b1000, {8'h5A, 8'h00, 8'h00, 8'h00});
    do_slot(-1, '0, '0);

    // Reset arrives at bit 4 of a granted slot.
    req     = 4'b0010;
    data_in = {8'h00, 8'h00, 8'hC3, 8'h00};
    @(posedge clk32f);
    #1;
    mon_en = 1'b0;
    repeat (4) begin
      @(posedge clk32f);
      #1;
    end
    rst = 1'b1;
    @(posedge clk32f);
    #1;
    chk_all_zero("midrst");
    rst     = 1'b0;
    m_ptr   = 0;
    m_slot  = 0;
    req     = 4'b0011;
    data_in = {8'h00, 8'h00, 8'h7E, 8'h81};
    do_slot(-1, '0, '0);
    do_slot(-1, '0, '0);

    // Random traffic, including changes in the middle of a slot.
    req     = N'($urandom);
    data_in = {$urandom, $urandom};
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 1) == 1)
        do_slot(int'($urandom_range(0, W - 1)), N'($urandom), {$urandom, $urandom});
      else
        do_slot(-1, '0, '0);
    end

    @(negedge clk32f);
    #1;
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
